daq_event_builder: RTL and testbench
====================================

# daq_event_builder

Formats channel data for the AMC13 DAQ link. Consumes the 32-bit AXI4-Stream readout that the channel width converter produces, packs it into 64-bit words, and frames each event with a header and a trailer. Drives the event-data side of the DAQ link (`EventData*`, `AlmostFull`, `Ready`), so it writes directly into `DAQ_Link_7S`. It runs in the 125 MHz domain shared with the stream converters.

## Interface
- `SOURCE_ID`, default 12'h001: source ID placed in the header.
- `MAX_PAYLOAD`, default 4096: maximum number of 64-bit payload words per event. Anything beyond this is dropped.
- `clk` in, 1 bit: 125 MHz clock. One clock domain only.
- `reset` in, 1 bit: synchronous, active-high.
- `s_axis_tdata` in, 32 bits: channel readout data.
- `s_axis_tvalid` in, 1 bit: source has a beat.
- `s_axis_tlast` in, 1 bit: last beat of the event.
- `s_axis_tready` out, 1 bit: builder accepts the beat.
- `daq_data` out, 64 bits: word to the DAQ link.
- `daq_valid` out, 1 bit: `daq_data` is valid this cycle.
- `daq_header` out, 1 bit: this word is the header.
- `daq_trailer` out, 1 bit: this word is the trailer.
- `daq_ready` in, 1 bit: DAQ link is up.
- `daq_almost_full` in, 1 bit: DAQ link buffer is nearly full.
- `evt_count` out, 24 bits: number of completed events. Wraps.

## Operation
- `can_send = daq_ready & ~daq_almost_full`, evaluated combinationally each cycle.
- **IDLE:**
  - `s_axis_tready` = 0.
  - If `s_axis_tvalid & can_send`, emit the header and go to PAYLOAD.
- **PAYLOAD:**
  - `s_axis_tready = can_send`.
  - Beats arrive as pairs. The first beat of a pair is latched as `hi`. The second beat emits `{hi, tdata}`.
  - `tlast` on the first beat of a pair: emit `{tdata, 32'h0}` in the same cycle, then go to TRAILER.
  - `tlast` on the second beat of a pair: emit the pair, then go to TRAILER.
  - Payload words beyond `MAX_PAYLOAD` are accepted but not emitted, and the overflow flag is set. Accepting them keeps the source draining.
- **TRAILER:**
  - When `can_send`, emit the trailer.
  - `evt_num` increments (24-bit, wraps 24'hFFFFFF→0).
  - Clear the word count, flag and half-select, then go to IDLE.
- **Header word:** `{4'h5, 4'h0, evt_num[23:0], 12'h000, SOURCE_ID[11:0], 8'h00}`.
- **Trailer word:** `{4'hA, 4'h0, 4'h0, wc[19:0], 16'h0000, 12'h000, ovf, 3'b000}`.
  - `wc` counts emitted words including header and trailer. It saturates at 20'hFFFFF.
  - `ovf` is bit 3.
- `evt_count` mirrors `evt_num`.
- Packing is big-endian: the first stream beat always lands in `[63:32]`.
- A zero-length event is not possible, because the header is only emitted when a beat is present.
- `can_send` dropping mid-event:
  - `tready` falls in the same cycle.
  - No word is emitted until it returns.
  - The latched half word and all state are held.

## Timing
- All DAQ outputs are registered.
  - `daq_valid` is a one-cycle pulse per word.
  - `daq_header` and `daq_trailer` are only ever asserted together with `daq_valid`.
- Header appears 1 cycle after the first cycle in which `s_axis_tvalid & can_send` holds in IDLE.
- A payload word appears 1 cycle after its completing beat is accepted.
- The trailer appears 1 cycle after the TRAILER state sees `can_send`.
- Peak throughput: one 64-bit word every 2 cycles.
- Reset, which may arrive mid-event, takes effect on the next edge:
  - all outputs go to 0 and `s_axis_tready` = 0;
  - state = IDLE;
  - `evt_num`, `wc`, `ovf` and `hi` are cleared.
  - The partial event is abandoned and no trailer is sent.
- When `daq_almost_full` asserts, output stops the next cycle. The link's almost-full margin absorbs that word.

## Structure
- Package `daq_pkg` holds:
  - the header marker 4'h5 and trailer marker 4'hA;
  - field widths (event number 24, word count 20, source ID 12);
  - the overflow bit position;
  - the state enum {IDLE, HEADER_WAIT, PAYLOAD, TRAILER}. HEADER_WAIT is unused and reserved for later.
- Single module with no sub-module. Packing and framing share one FSM.

## Test plan
- **Single event:** 4 beats 32'h00000001 to 32'h00000004, with `tlast` on beat 4, while `daq_ready`=1 and `daq_almost_full`=0.
  - Expect exactly 4 words in order: header, 64'h0000000100000002, 64'h0000000300000004, trailer.
  - Header has evt_num 0 and `SOURCE_ID`. Trailer has wc 4 and ovf 0.
- **Odd length:** 3 beats A, B, C.
  - Payload is `{A,B}` then `{C,32'h0}`. Trailer wc is 4.
- **Backpressure:** toggle `daq_almost_full` every 3 cycles during a 10-beat event.
  - No output word is emitted and no beat is accepted while it is high.
  - Data is intact. wc is 7.
- **Overflow:** `MAX_PAYLOAD`=2, send 8 beats.
  - Only the first 2 payload words are emitted and all beats are consumed.
  - Trailer has ovf=1 and wc=4.
- **Reset mid-event:** assert `reset` after the header and one payload word.
  - Next cycle all outputs are 0.
  - The following event carries evt_num 0 and a fresh word count.
- **Wrap:** preload `evt_num` to 24'hFFFFFF via force and run two events.
  - Headers show FFFFFF then 000000.

Source files
------------

// File: rtl/daq_pkg.sv
// Shared constants, state encoding and word-building helpers for the DAQ event builder.
package daq_pkg;

    localparam int EVT_W   = 24;
    localparam int WC_W    = 20;
    localparam int SRC_W   = 12;
    localparam int OVF_BIT = 3;

    localparam logic [3:0] HDR_MARK = 4'h5;
    localparam logic [3:0] TRL_MARK = 4'hA;

    // HEADER_WAIT is reserved; the FSM never enters it on purpose.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_HEADER_WAIT = 2'd1,
        ST_PAYLOAD     = 2'd2,
        ST_TRAILER     = 2'd3
    } state_t;

    function automatic logic [63:0] make_header(input logic [EVT_W-1:0] evt,
                                                input logic [SRC_W-1:0] src);
        return {HDR_MARK, 4'h0, evt, 12'h000, src, 8'h00};
    endfunction

    function automatic logic [63:0] make_trailer(input logic [WC_W-1:0] wc,
                                                 input logic ovf);
        logic [63:0] w;
        w          = {TRL_MARK, 4'h0, 4'h0, wc, 16'h0000, 12'h000, 4'h0};
        w[OVF_BIT] = ovf;
        return w;
    endfunction

    // Word count saturates rather than wrapping so a huge event never reports a tiny count.
    function automatic logic [WC_W-1:0] wc_inc(input logic [WC_W-1:0] wc);
        if (wc == {WC_W{1'b1}}) begin
            return wc;
        end else begin
            return wc + WC_W'(1);
        end
    endfunction

endpackage

// File: rtl/daq_event_builder.sv
// Packs 32-bit stream beats into 64-bit words and frames each event with header/trailer.
module daq_event_builder
    import daq_pkg::*;
#(
    parameter logic [11:0] SOURCE_ID   = 12'h001,
    parameter int          MAX_PAYLOAD = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [63:0] daq_data,
    output logic        daq_valid,
    output logic        daq_header,
    output logic        daq_trailer,
    input  logic        daq_ready,
    input  logic        daq_almost_full,
    output logic [23:0] evt_count
);

    localparam logic [31:0] MAX_PAY_U = 32'(MAX_PAYLOAD);

    state_t             state_q, state_d;
    logic [31:0]        hi_q, hi_d;
    logic               half_q, half_d;
    logic [31:0]        pay_cnt_q, pay_cnt_d;
    logic [WC_W-1:0]    wc_q, wc_d;
    logic               ovf_q, ovf_d;
    logic [EVT_W-1:0]   evt_num_q, evt_num_d;
    logic [63:0]        data_q, data_d;
    logic               valid_q, valid_d;
    logic               hdr_q, hdr_d;
    logic               trl_q, trl_d;
    logic               can_send_s;
    logic               accept_s;

    // Next-state, packing and framing decisions for the single event FSM.
    always_comb begin
        state_d       = state_q;
        hi_d          = hi_q;
        half_d        = half_q;
        pay_cnt_d     = pay_cnt_q;
        wc_d          = wc_q;
        ovf_d         = ovf_q;
        evt_num_d     = evt_num_q;
        data_d        = 64'h0;
        valid_d       = 1'b0;
        hdr_d         = 1'b0;
        trl_d         = 1'b0;
        s_axis_tready = 1'b0;
        can_send_s    = daq_ready & ~daq_almost_full;
        accept_s      = s_axis_tvalid & can_send_s;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    valid_d = 1'b1;
                    hdr_d   = 1'b1;
                    data_d  = make_header(evt_num_q, SOURCE_ID);
                    wc_d    = WC_W'(1);
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                s_axis_tready = can_send_s;
                if (accept_s && !half_q && !s_axis_tlast) begin
                    hi_d   = s_axis_tdata;
                    half_d = 1'b1;
                end else if (accept_s) begin
                    // A completed word: either a full pair or a zero-padded last half.
                    if (half_q) begin
                        data_d = {hi_q, s_axis_tdata};
                    end else begin
                        data_d = {s_axis_tdata, 32'h0};
                    end
                    half_d = 1'b0;
                    if (pay_cnt_q < MAX_PAY_U) begin
                        valid_d   = 1'b1;
                        pay_cnt_d = pay_cnt_q + 32'd1;
                        wc_d      = wc_inc(wc_q);
                    end else begin
                        // Dropped word still consumes the beats so the source keeps draining.
                        data_d = 64'h0;
                        ovf_d  = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        state_d = ST_TRAILER;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_TRAILER: begin
                if (can_send_s) begin
                    valid_d   = 1'b1;
                    trl_d     = 1'b1;
                    data_d    = make_trailer(wc_inc(wc_q), ovf_q);
                    evt_num_d = evt_num_q + EVT_W'(1);
                    wc_d      = '0;
                    pay_cnt_d = 32'd0;
                    ovf_d     = 1'b0;
                    half_d    = 1'b0;
                    hi_d      = 32'h0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_TRAILER;
                end
            end
            ST_HEADER_WAIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered DAQ outputs; reset abandons any partial event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hi_q      <= 32'h0;
            half_q    <= 1'b0;
            pay_cnt_q <= 32'd0;
            wc_q      <= '0;
            ovf_q     <= 1'b0;
            evt_num_q <= '0;
            data_q    <= 64'h0;
            valid_q   <= 1'b0;
            hdr_q     <= 1'b0;
            trl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            half_q    <= half_d;
            pay_cnt_q <= pay_cnt_d;
            wc_q      <= wc_d;
            ovf_q     <= ovf_d;
            evt_num_q <= evt_num_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            hdr_q     <= hdr_d;
            trl_q     <= trl_d;
        end
    end

    assign daq_data    = data_q;
    assign daq_valid   = valid_q;
    assign daq_header  = hdr_q;
    assign daq_trailer = trl_q;
    assign evt_count   = evt_num_q;

endmodule

// File: tb/tb_daq_event_builder.sv
// Randomized bench for daq_event_builder: two instances (default and MAX_PAYLOAD=2) in lockstep.
module tb_daq_event_builder;

    logic        clk;
    logic        reset;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        daq_ready;
    logic        daq_af;

    logic        tready0, valid0, hdr0, trl0;
    logic [63:0] data0;
    logic [23:0] evc0;
    logic        tready1, valid1, hdr1, trl1;
    logic [63:0] data1;
    logic [23:0] evc1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [65:0] q0[$];
    logic [65:0] q1[$];
    int          trl0_cnt = 0;
    int          trl1_cnt = 0;
    int          exp_trl = 0;
    logic [23:0] evt_m = 24'h0;
    bit          mon_en = 1'b0;
    bit          cs_edge = 1'b0;
    int          bp_mode = 0;
    int          bp_cnt = 0;

    daq_event_builder #(.SOURCE_ID(12'h001), .MAX_PAYLOAD(4096)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .s_axis_tready(tready0),
        .daq_data(data0), .daq_valid(valid0), .daq_header(hdr0), .daq_trailer(trl0),
        .daq_ready(daq_ready), .daq_almost_full(daq_af), .evt_count(evc0)
    );

    daq_event_builder #(.SOURCE_ID(12'h001), .MAX_PAYLOAD(2)) dut_ovf (
        .clk(clk), .reset(reset),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .s_axis_tready(tready1),
        .daq_data(data1), .daq_valid(valid1), .daq_header(hdr1), .daq_trailer(trl1),
        .daq_ready(daq_ready), .daq_almost_full(daq_af), .evt_count(evc1)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr_word(input logic [23:0] evt);
        return {4'h5, 4'h0, evt, 12'h000, 12'h001, 8'h00};
    endfunction

    function automatic logic [63:0] trl_word(input int wc, input bit ovf);
        return {4'hA, 4'h0, 4'h0, 20'(wc), 16'h0000, 12'h000, ovf, 3'b000};
    endfunction

    // Link-side permission as seen by the edge that launches the next output word.
    initial forever begin
        @(posedge clk);
        cs_edge = daq_ready && !daq_af;
    end

    // Output capture plus framing/stall protocol checks.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (valid0) begin
                q0.push_back({hdr0, trl0, data0});
                if (trl0) trl0_cnt++;
            end
            if (valid1) begin
                q1.push_back({hdr1, trl1, data1});
                if (trl1) trl1_cnt++;
            end
            check("proto", {62'h0, valid0 & ~cs_edge, (hdr0 | trl0) & ~valid0,
                            valid1 & ~cs_edge, (hdr1 | trl1) & ~valid1}, 66'h0);
        end
    end

    // Link backpressure generator: off, toggle every 3 cycles, or random.
    initial forever begin
        @(negedge clk);
        case (bp_mode)
            1: begin
                bp_cnt++;
                if (bp_cnt == 3) begin
                    bp_cnt = 0;
                    daq_af = ~daq_af;
                end
            end
            2: begin
                daq_af    = ($urandom_range(0, 3) == 0);
                daq_ready = ($urandom_range(0, 7) != 0);
            end
            default: ;
        endcase
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input bit last);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            tvalid = 1'b1;
            tdata  = d;
            tlast  = last;
            #1;
            if (!(daq_ready && !daq_af))
                check("rdy_stall", {64'h0, tready0, tready1}, 66'h0);
            if (tready0) done = 1'b1;
            @(posedge clk);
            n++;
            if (!done && n > 300) begin
                check("beat_timeout", 66'(n), 66'h0);
                done = 1'b1;
            end
        end
    endtask

    task automatic wait_trailers(input int target);
        int n;
        n = 0;
        while ((trl0_cnt < target || trl1_cnt < target) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) check("trl_timeout", 66'(trl0_cnt), 66'(target));
    endtask

    task automatic compare_event(input int which, input logic [31:0] beats[$],
                                 input logic [23:0] evt, input int maxp);
        logic [65:0] exp[$];
        logic [65:0] got[$];
        logic [31:0] lo;
        int nw, kept;
        nw   = (beats.size() + 1) / 2;
        kept = (nw < maxp) ? nw : maxp;
        exp.push_back({2'b10, hdr_word(evt)});
        for (int i = 0; i < kept; i++) begin
            lo = (2 * i + 1 < beats.size()) ? beats[2 * i + 1] : 32'h0;
            exp.push_back({2'b00, beats[2 * i], lo});
        end
        exp.push_back({2'b01, trl_word(kept + 2, nw > maxp)});
        if (which == 0) begin
            got = q0;
            q0.delete();
        end else begin
            got = q1;
            q1.delete();
        end
        check($sformatf("nwords%0d", which), 66'(got.size()), 66'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size())
                check($sformatf("word%0d[%0d]", which, i), got[i], exp[i]);
    endtask

    task automatic run_event(input logic [31:0] beats[$], input int gap_max);
        for (int i = 0; i < beats.size(); i++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            drive_beat(beats[i], i == beats.size() - 1);
        end
        idle(1);
        exp_trl++;
        wait_trailers(exp_trl);
        compare_event(0, beats, evt_m, 4096);
        compare_event(1, beats, evt_m, 2);
        evt_m = evt_m + 24'd1;
        @(negedge clk);
        check("evt_count0", {42'h0, evc0}, {42'h0, evt_m});
        check("evt_count1", {42'h0, evc1}, {42'h0, evt_m});
    endtask

    function automatic void rand_beats(input int n, output logic [31:0] b[$]);
        b.delete();
        for (int i = 0; i < n; i++) b.push_back($urandom);
    endfunction

    initial begin
        logic [31:0] beats[$];
        reset     = 1'b1;
        tdata     = 32'h0;
        tvalid    = 1'b0;
        tlast     = 1'b0;
        daq_ready = 1'b1;
        daq_af    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {60'h0, valid0, hdr0, trl0, tready0, valid1, hdr1}, 66'h0);
        check("rst_data", {2'b0, data0 | data1}, 66'h0);
        check("rst_evc", {42'h0, evc0 | evc1}, 66'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single event 1..4
        beats = '{32'h1, 32'h2, 32'h3, 32'h4};
        run_event(beats, 0);

        // Odd length
        beats = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        run_event(beats, 0);

        // Backpressure toggling every 3 cycles, 10 beats
        rand_beats(10, beats);
        bp_cnt  = 0;
        bp_mode = 1;
        run_event(beats, 0);
        bp_mode = 0;
        @(negedge clk);
        daq_af = 1'b0;

        // Overflow on the MAX_PAYLOAD=2 instance
        rand_beats(8, beats);
        run_event(beats, 0);

        // Reset after header and one payload word, with a half word latched
        drive_beat(32'h1111_1111, 1'b0);
        drive_beat(32'h2222_2222, 1'b0);
        drive_beat(32'h3333_3333, 1'b0);
        idle(3);
        check("pre_rst_n", 66'(q0.size()), 66'd2);
        if (q0.size() >= 2) begin
            check("pre_rst_hdr", q0[0], {2'b10, hdr_word(evt_m)});
            check("pre_rst_w", q0[1], {2'b00, 64'h1111_1111_2222_2222});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_ctl", {62'h0, valid0, hdr0, trl0, tready0}, 66'h0);
        check("mid_rst_data", {2'b0, data0}, 66'h0);
        check("mid_rst_evc", {42'h0, evc0}, 66'h0);
        reset = 1'b0;
        q0.delete();
        q1.delete();
        evt_m = 24'h0;
        rand_beats(5, beats);
        run_event(beats, 1);

        // Event-number wrap
        @(negedge clk);
        force dut.evt_num_q = 24'hFFFFFF;
        force dut_ovf.evt_num_q = 24'hFFFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.evt_num_q;
        release dut_ovf.evt_num_q;
        evt_m = 24'hFFFFFF;
        rand_beats(4, beats);
        run_event(beats, 0);
        rand_beats(3, beats);
        run_event(beats, 0);

        // Random traffic with random link stalls and source gaps
        bp_mode = 2;
        for (int e = 0; e < 20; e++) begin
            rand_beats($urandom_range(1, 12), beats);
            run_event(beats, 2);
        end
        bp_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
